// File: rtl/alu_sel_pkg.sv
// Shared types, defaults and sizing helper for the ALU result selector.
package alu_sel_pkg;

    // Controller states: normal request handling, or sequential emission of every source.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NSRC  = 8;

    // Select/index width for a given source count; never narrower than one bit.
    function automatic int calc_selw(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/out_reg_slice.sv
// One-entry valid/ready output register. A load may coincide with a consume,
// which lets a new word replace the old one in the same cycle.
module out_reg_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] din,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] dout,
    output logic          slot_free
);

    logic          valid_r;
    logic [PW-1:0] data_r;

    // The slot may be written when it is empty or its word leaves this cycle.
    assign slot_free = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign dout      = data_r;

    // Holding register: load wins, otherwise clear on consume, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {PW{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/alu_result_sel.sv
// Registered result selector: picks one of NSRC sources per accepted request,
// or walks every source in index order when a scan is requested.
module alu_result_sel
    import alu_sel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int SELW  = calc_selw(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] src_bus,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic                  scan_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_idx,
    output logic                  out_err,
    output logic                  scan_busy,
    output logic                  scan_done
);

    localparam int              PW       = WIDTH + SELW + 1;
    localparam logic [SELW:0]   NSRC_L   = (SELW+1)'(NSRC);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NSRC - 1);

    state_e            state_r;
    state_e            state_nx_s;
    logic [SELW-1:0]   scan_cnt_r;
    logic [SELW-1:0]   cnt_nx_s;
    logic              scan_done_r;
    logic              done_nx_s;

    logic              slot_free_s;
    logic              in_range_s;
    logic              load_s;
    logic              load_err_s;
    logic [SELW-1:0]   load_idx_s;
    logic [SELW-1:0]   pick_idx_s;
    logic [WIDTH-1:0]  load_data_s;
    logic [PW-1:0]     slice_dout_s;

    assign in_range_s = ({1'b0, sel} < NSRC_L);
    assign in_ready   = (state_r == IDLE) && !scan_req && slot_free_s;
    assign scan_busy  = (state_r == SCAN);
    assign scan_done  = scan_done_r;

    // Next-state, scan counter and load decision; a scan request in IDLE pre-empts any select request.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = scan_cnt_r;
        done_nx_s  = 1'b0;
        load_s     = 1'b0;
        load_err_s = 1'b0;
        load_idx_s = sel;
        pick_idx_s = {SELW{1'b0}};
        case (state_r)
            IDLE: begin
                if (scan_req) begin
                    state_nx_s = SCAN;
                    cnt_nx_s   = {SELW{1'b0}};
                end else if (in_valid && slot_free_s) begin
                    load_s     = 1'b1;
                    load_idx_s = sel;
                    load_err_s = !in_range_s;
                    pick_idx_s = in_range_s ? sel : {SELW{1'b0}};
                end else begin
                    load_s = 1'b0;
                end
            end
            SCAN: begin
                if (slot_free_s) begin
                    load_s     = 1'b1;
                    load_idx_s = scan_cnt_r;
                    pick_idx_s = scan_cnt_r;
                    if (scan_cnt_r == LAST_IDX) begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = {SELW{1'b0}};
                        done_nx_s  = 1'b1;
                    end else begin
                        cnt_nx_s = scan_cnt_r + 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {SELW{1'b0}};
            end
        endcase
    end

    // Source part-select; the index is clamped in range, and out-of-range requests load zero.
    always_comb begin
        load_data_s = {WIDTH{1'b0}};
        if (load_err_s) begin
            load_data_s = {WIDTH{1'b0}};
        end else begin
            load_data_s = src_bus[pick_idx_s*WIDTH +: WIDTH];
        end
    end

    // Controller state, scan position and the end-of-scan pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            scan_cnt_r  <= {SELW{1'b0}};
            scan_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            scan_cnt_r  <= cnt_nx_s;
            scan_done_r <= done_nx_s;
        end
    end

    out_reg_slice #(
        .PW (PW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .din       ({load_err_s, load_idx_s, load_data_s}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (slice_dout_s),
        .slot_free (slot_free_s)
    );

    assign {out_err, out_idx, out_data} = slice_dout_s;

endmodule

// File: tb/tb_alu_result_sel.sv
// Scoreboard bench for alu_result_sel: an 8-source instance for the main
// function and a 6-source instance for the out-of-range select.
module tb_alu_result_sel;

    typedef struct packed {
        logic       err;
        logic [2:0] idx;
        logic [3:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    // 8-source instance
    logic [3:0]  src_a [8];
    logic [31:0] src_bus;
    logic        in_valid, in_ready, scan_req, out_valid, out_ready;
    logic        out_err, scan_busy, scan_done;
    logic [2:0]  sel, out_idx;
    logic [3:0]  out_data;

    // 6-source instance
    logic [23:0] b_src_bus;
    logic        b_in_valid, b_in_ready, b_scan_req, b_out_valid, b_out_ready;
    logic        b_out_err, b_scan_busy, b_scan_done;
    logic [2:0]  b_sel, b_out_idx;
    logic [3:0]  b_out_data;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Pack the per-source table onto the flat bus.
    always_comb begin
        src_bus = 32'd0;
        for (int i = 0; i < 8; i++) src_bus[i*4 +: 4] = src_a[i];
    end

    alu_result_sel #(.WIDTH(4), .NSRC(8)) dut (
        .clk(clk), .rst(rst), .src_bus(src_bus), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .scan_req(scan_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_err(out_err), .scan_busy(scan_busy),
        .scan_done(scan_done)
    );

    alu_result_sel #(.WIDTH(4), .NSRC(6)) dut_b (
        .clk(clk), .rst(rst), .src_bus(b_src_bus), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .scan_req(b_scan_req),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_err(b_out_err), .scan_busy(b_scan_busy),
        .scan_done(b_scan_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: every word handed downstream must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            chk("sb_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_word", 32'({out_err, out_idx, out_data}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        exp_t e;
        e.err  = 1'b0;
        e.idx  = s;
        e.data = src_a[s];
        sb.push_back(e);
        in_valid = 1'b1;
        sel      = s;
        @(negedge clk);
        chk("in_ready_acc", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_scan();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.err  = 1'b0;
            e.idx  = 3'(i);
            e.data = src_a[i];
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; in_valid = 1'b1; sel = 3'd0; scan_req = 1'b0; out_ready = 1'b1;
        b_src_bus = 24'h000000; b_in_valid = 1'b0; b_sel = 3'd0;
        b_scan_req = 1'b0; b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) src_a[i] = 4'(i);

        // Reset held for two cycles with a request pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_scan_busy", 32'(scan_busy), 32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Single select, one-cycle latency
        src_a[3] = 4'hA;
        send(3'd3);
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", 32'(out_data), 32'hA);
        tick();

        // Back-to-back selects
        src_a[0] = 4'h5; src_a[1] = 4'hC; src_a[7] = 4'h3;
        send(3'd0);
        send(3'd1);
        send(3'd7);
        @(negedge clk);
        chk("b2b_last_idx", 32'(out_idx), 32'd7);
        tick();
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);
        tick();

        // Backpressure: word held, requests refused, source may change afterwards
        src_a[5] = 4'h6;
        out_ready = 1'b0;
        send(3'd5);
        src_a[5] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            sel = 3'(k + 1);
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h6);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        src_a[2] = 4'h9;
        tick();
        send(3'd2);
        tick();

        // Scan with a conflicting select request in the scan_req cycle
        for (int i = 0; i < 8; i++) src_a[i] = 4'(i + 1);
        push_scan();
        scan_req = 1'b1; in_valid = 1'b1; sel = 3'd2;
        @(negedge clk);
        chk("scan_conflict_in_ready", 32'(in_ready), 32'd0);
        tick();
        scan_req = 1'b0; in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("scan_busy_hi", 32'(scan_busy), 32'd1);
            chk("scan_done_lo", 32'(scan_done), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("scan_done_pulse", 32'(scan_done), 32'd1);
        chk("scan_done_idx", 32'(out_idx), 32'd7);
        chk("scan_busy_end", 32'(scan_busy), 32'd0);
        chk("scan_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("scan_done_once", 32'(scan_done), 32'd0);
        tick();

        // Reset in the middle of a scan with out_ready toggling
        for (int i = 0; i < 8; i++) src_a[i] = 4'(15 - i);
        push_scan();
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (out_valid && out_idx == 3'd3) begin
                found = 1'b1;
                break;
            end
            tick();
            out_ready = ~out_ready;
        end
        chk("midscan_idx3_seen", 32'(found), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_idx", 32'(out_idx), 32'd0);
        chk("midrst_scan_busy", 32'(scan_busy), 32'd0);
        chk("midrst_scan_done", 32'(scan_done), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(scan_done), 32'd0);
            chk("post_rst_idle", 32'(in_ready), 32'd1);
            tick();
        end

        // Out-of-range select on the 6-source instance, then an in-range one
        b_src_bus = 24'h98_7654;
        b_in_valid = 1'b1; b_sel = 3'd7;
        @(negedge clk);
        chk("b_in_ready", 32'(b_in_ready), 32'd1);
        tick();
        b_sel = 3'd5;
        @(negedge clk);
        chk("b_oor_valid", 32'(b_out_valid), 32'd1);
        chk("b_oor_data", 32'(b_out_data), 32'd0);
        chk("b_oor_err", 32'(b_out_err), 32'd1);
        chk("b_oor_idx", 32'(b_out_idx), 32'd7);
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_ok_data", 32'(b_out_data), 32'h9);
        chk("b_ok_err", 32'(b_out_err), 32'd0);
        chk("b_ok_idx", 32'(b_out_idx), 32'd5);
        chk("b_scan_idle", 32'({b_scan_busy, b_scan_done}), 32'd0);
        tick();

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
